// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types, constants and segment map for the display scan path
package display_pkg;

    typedef enum logic [1:0] {
        GAP_A,
        U_ON,
        GAP_B,
        T_ON
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [1:0] AN_OFF    = 2'b11;
    localparam logic [1:0] AN_UNITS  = 2'b10;
    localparam logic [1:0] AN_TENS   = 2'b01;

    // Active-low {g,f,e,d,c,b,a}; anything outside 0-9 shows blank.
    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/gray_decoder.sv
// rtl/gray_decoder.sv - combinational Gray to binary conversion
module gray_decoder #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] binary
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign binary[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/gray_input_filter.sv
// rtl/gray_input_filter.sv - two-flop synchronizer plus stability filter for the Gray input
module gray_input_filter #(
    parameter int STABLE_CYCLES = 270000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] gray_code,
    output logic [3:0] committed,
    output logic       value_valid
);

    localparam int             CW      = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    committed_q, committed_d;
    logic          valid_q, valid_d;

    always_comb begin
        sync1_d     = gray_code;
        sync2_d     = sync1_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        committed_d = committed_q;
        valid_d     = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
            // Saturated: commit only once per distinct candidate.
            if (cand_q != committed_q) begin
                committed_d = cand_q;
                valid_d     = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            committed_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            committed_q <= committed_d;
            valid_q     <= valid_d;
        end
    end

    assign committed   = committed_q;
    assign value_valid = valid_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - filtered Gray input shown as two time-multiplexed 7-segment digits
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int SCAN_DIV      = 27000,
    parameter int BLANK_CYCLES  = 270,
    parameter int STABLE_CYCLES = 270000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] gray_code,
    output logic [6:0] display_code,
    output logic [1:0] an,
    output logic       y,
    output logic       value_valid
);

    localparam int            MAXC       = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int            TW         = $clog2(MAXC + 1);
    localparam logic [TW-1:0] LOAD_SCAN  = TW'(SCAN_DIV);
    localparam logic [TW-1:0] LOAD_BLANK = TW'(BLANK_CYCLES);
    localparam logic [TW-1:0] TMR_LAST   = TW'(1);

    logic [3:0] committed;
    logic       commit_pulse;
    logic [3:0] binary;
    logic       tens;
    logic [3:0] units;

    gray_input_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .gray_code  (gray_code),
        .committed  (committed),
        .value_valid(commit_pulse)
    );

    gray_decoder #(
        .W(4)
    ) u_decoder (
        .gray  (committed),
        .binary(binary)
    );

    assign tens  = (binary >= 4'd10);
    assign units = tens ? (binary - 4'd10) : binary;

    scan_state_t   state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          snap_t_q, snap_t_d;
    logic [3:0]    snap_u_q, snap_u_d;
    logic [6:0]    disp_q, disp_d;
    logic [1:0]    an_q, an_d;
    logic          y_q, y_d;
    logic          vv_q, vv_d;

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q - 1'b1;
        snap_t_d = snap_t_q;
        snap_u_d = snap_u_q;
        if (tmr_q == TMR_LAST) begin
            case (state_q)
                GAP_A: begin
                    // Snapshot uses the pre-edge committed value, so a
                    // simultaneous commit lands in the next frame.
                    state_d  = U_ON;
                    tmr_d    = LOAD_SCAN;
                    snap_t_d = tens;
                    snap_u_d = units;
                end
                U_ON: begin
                    state_d = GAP_B;
                    tmr_d   = LOAD_BLANK;
                end
                GAP_B: begin
                    state_d = T_ON;
                    tmr_d   = LOAD_SCAN;
                end
                default: begin
                    state_d = GAP_A;
                    tmr_d   = LOAD_BLANK;
                end
            endcase
        end
    end

    always_comb begin
        disp_d = SEG_BLANK;
        an_d   = AN_OFF;
        y_d    = tens;
        vv_d   = commit_pulse;
        case (state_q)
            U_ON: begin
                disp_d = seg_of(snap_u_q);
                an_d   = AN_UNITS;
            end
            T_ON: begin
                if (snap_t_q) begin
                    disp_d = seg_of(4'd1);
                    an_d   = AN_TENS;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= GAP_A;
            tmr_q    <= LOAD_BLANK;
            snap_t_q <= 1'b0;
            snap_u_q <= '0;
            disp_q   <= SEG_BLANK;
            an_q     <= AN_OFF;
            y_q      <= 1'b0;
            vv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            snap_t_q <= snap_t_d;
            snap_u_q <= snap_u_d;
            disp_q   <= disp_d;
            an_q     <= an_d;
            y_q      <= y_d;
            vv_q     <= vv_d;
        end
    end

    assign display_code = disp_q;
    assign an           = an_q;
    assign y            = y_q;
    assign value_valid  = vv_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl against a frame-level model
module tb_display_scan_ctrl;

    localparam int SD = 4;
    localparam int BC = 1;
    localparam int ST = 3;
    localparam int F  = 2 * (SD + BC);

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] gray_code = 4'd0;
    logic [6:0] display_code;
    logic [1:0] an;
    logic       y;
    logic       value_valid;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC),
        .STABLE_CYCLES(ST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .gray_code   (gray_code),
        .display_code(display_code),
        .an          (an),
        .y           (y),
        .value_valid (value_valid)
    );

    int total = 0;
    int bad   = 0;

    // Model: edges since reset release, input samples per edge, committed value.
    int         c;
    logic [3:0] samp[$];
    logic [3:0] m_comm;
    logic       m_vv_pend;
    logic       m_snap_t;
    logic [3:0] m_snap_u;
    logic [6:0] e_disp;
    logic [1:0] e_an;
    logic       e_y;
    logic       e_vv;
    logic [1:0] prev_an;
    logic [6:0] seg_tab[10];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%h expected=%h", tag, c, obs, exp_v);
        end
    endtask

    function automatic int g2b(input logic [3:0] g);
        int v;
        v = int'(g);
        return v ^ (v >> 1) ^ (v >> 2) ^ (v >> 3);
    endfunction

    // 0=GAP_A 1=U_ON 2=GAP_B 3=T_ON, for the state holding after edge cc.
    function automatic int phase_state(input int cc);
        int t;
        t = cc % F;
        if (t < BC) return 0;
        if (t < BC + SD) return 1;
        if (t < 2 * BC + SD) return 2;
        return 3;
    endfunction

    function automatic logic [3:0] sample_at(input int e);
        if (e < 1) return 4'd0;
        return samp[e];
    endfunction

    task automatic model_reset();
        c = 0;
        samp.delete();
        samp.push_back(4'd0);
        m_comm    = 4'd0;
        m_vv_pend = 1'b0;
        m_snap_t  = 1'b0;
        m_snap_u  = 4'd0;
        prev_an   = 2'b11;
    endtask

    task automatic model_edge(input logic [3:0] g);
        int         ps;
        int         b;
        logic [3:0] v;
        bit         ok;
        c++;
        samp.push_back(g);
        ps = phase_state(c - 1);
        e_disp = 7'h7F;
        e_an   = 2'b11;
        if (ps == 1) begin
            e_disp = seg_tab[m_snap_u];
            e_an   = 2'b10;
        end else if (ps == 3 && m_snap_t) begin
            e_disp = 7'h79;
            e_an   = 2'b01;
        end
        b    = g2b(m_comm);
        e_y  = (b >= 10);
        e_vv = m_vv_pend;
        if (c % F == BC) begin
            m_snap_t = (b >= 10);
            m_snap_u = 4'(b % 10);
        end
        // A value commits once the raw input has held it for ST+1 samples, two edges of sync earlier.
        m_vv_pend = 1'b0;
        v  = sample_at(c - ST - 2);
        ok = 1'b1;
        for (int e = c - ST - 2; e <= c - 2; e++) begin
            if (sample_at(e) != v) ok = 1'b0;
        end
        if (ok && v != m_comm) begin
            m_comm    = v;
            m_vv_pend = 1'b1;
        end
    endtask

    task automatic check_cycle();
        chk("display_code", {1'b0, display_code}, {1'b0, e_disp});
        chk("an", {6'd0, an}, {6'd0, e_an});
        chk("y", {7'd0, y}, {7'd0, e_y});
        chk("value_valid", {7'd0, value_valid}, {7'd0, e_vv});
        chk("an_both_on", {7'd0, (an == 2'b00)}, 8'd0);
        chk("digit_gap", {7'd0, ((prev_an == 2'b10 && an == 2'b01) || (prev_an == 2'b01 && an == 2'b10))}, 8'd0);
        prev_an = an;
    endtask

    task automatic step(input logic [3:0] g);
        gray_code = g;
        @(posedge clk);
        model_edge(g);
        @(negedge clk);
        check_cycle();
    endtask

    task automatic hold(input logic [3:0] g, input int n);
        for (int i = 0; i < n; i++) step(g);
    endtask

    task automatic check_blank(input string tag);
        chk({tag, "_disp"}, {1'b0, display_code}, 8'h7F);
        chk({tag, "_an"}, {6'd0, an}, 8'h03);
        chk({tag, "_y"}, {7'd0, y}, 8'd0);
        chk({tag, "_vv"}, {7'd0, value_valid}, 8'd0);
    endtask

    initial begin
        bit found;
        logic [3:0] nv;
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        model_reset();

        // Reset state and first frame
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_blank("reset");
        end
        rst_n = 1'b1;
        hold(4'b0000, 2 * F + 2);

        // 15, then 10, then 6
        hold(4'b1000, 3 * F);
        hold(4'b1111, 3 * F);
        hold(4'b0101, 3 * F);

        // Short glitch discarded, then a held value commits
        hold(4'b0001, 2);
        hold(4'b0101, 10);
        hold(4'b0001, 10);

        // Commit landing on the U_ON entry edge, then one mid-U_ON
        found = 1'b0;
        for (int i = 0; i < 2 * F && !found; i++) begin
            if ((c + 6) % F == BC) found = 1'b1;
            else step(4'b0001);
        end
        chk("align_entry", {7'd0, found}, 8'd1);
        hold(4'b1100, 2 * F);
        found = 1'b0;
        for (int i = 0; i < 2 * F && !found; i++) begin
            if ((c + 6) % F == BC + 2) found = 1'b1;
            else step(4'b1100);
        end
        chk("align_mid", {7'd0, found}, 8'd1);
        hold(4'b0110, 2 * F);

        // Randomized segments of held values and glitches
        for (int k = 0; k < 40; k++) begin
            nv = 4'($urandom_range(0, 15));
            hold(nv, $urandom_range(1, 12));
        end

        // Reset in the middle of a visible tens digit
        hold(4'b1111, 3 * F);
        found = 1'b0;
        for (int i = 0; i < 2 * F && !found; i++) begin
            if (phase_state(c - 1) == 3 && phase_state(c) == 3) found = 1'b1;
            else step(4'b1111);
        end
        chk("find_t_on", {7'd0, found}, 8'd1);
        chk("t_on_visible", {6'd0, an}, 8'h01);
        #2 rst_n = 1'b0;
        #1 check_blank("midreset");
        @(negedge clk);
        check_blank("midreset_hold");
        model_reset();
        rst_n = 1'b1;
        hold(4'b0000, 2 * F + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Sequencing controller for the Gray-to-7-segment path. It synchronizes and debounces the 4-bit Gray input and converts it to binary. It splits the value into tens and units and time-multiplexes both digits onto one shared segment bus, with a blanking gap between digits. It sits between the board switches and the two-digit display, and supplies the digit-select mux and the tens indicator that the top level needs.

## Interface
- SCAN_DIV, 27000: cycles each digit stays lit (≥2; 1 kHz per digit at 27 MHz).
- BLANK_CYCLES, 270: cycles with all digits off between digits, for anti-ghosting (≥1).
- STABLE_CYCLES, 270000: cycles the synchronized input must stay constant before it is committed (≥2).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- gray_code  in  4  raw Gray code from the switches (asynchronous to clk).
- display_code  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  2  digit enables, active-low; an[0] is units, an[1] is tens.
- y  out  1  1 when the committed value is ≥10.
- value_valid  out  1  one-cycle pulse when a new value is committed.

## Operation
- **Synchronizer:** 2-flop chain on gray_code, producing gray_sync.
- **Filter registers:** cand and cnt.
  - gray_sync≠cand: cand←gray_sync, cnt←0.
  - Else, if cnt==STABLE_CYCLES-1 and cand≠committed: committed←cand and value_valid=1 for one cycle.
  - Else: cnt saturates at STABLE_CYCLES-1.
- **Conversion:** combinational from committed.
  - binary[3]=g[3]; binary[i]=binary[i+1]^g[i].
  - tens = binary≥10; units = tens ? binary-10 : binary (4-bit, range 0–9 for every legal input, so no overflow).
- **Snapshot:** tens and units are captured into snap_t and snap_u on entry to U_ON. A digit never changes mid-frame.
- **Scan FSM:** states GAP_A → U_ON → GAP_B → T_ON → GAP_A.
  - U_ON and T_ON last SCAN_DIV cycles each.
  - GAP_A and GAP_B last BLANK_CYCLES cycles each.
  - One shared down-counter is reloaded on every transition.
- **Registered outputs**, decoded from the state in the same cycle:
  - GAP_*: display_code=7'h7F, an=2'b11.
  - U_ON: display_code=seg(snap_u), an=2'b10.
  - T_ON: if snap_t, display_code=seg(1)=7'h79 and an=2'b01. Otherwise the leading zero is suppressed: display_code=7'h7F, an=2'b11.
- **Segment map, 0–9:** 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex, active-low).
- **y:** registered copy of tens of committed. It tracks committed, not the snapshot.
- **Simultaneous events:** a commit on the same edge as U_ON entry is not captured; the snapshot takes the pre-commit value, and the new value appears next frame.

## Timing
- **Reset values:**
  - display_code=7'h7F, an=2'b11, y=0, value_valid=0.
  - committed=cand=0, cnt=0, snap_t=0, snap_u=0.
  - State GAP_A with the counter loaded to BLANK_CYCLES.
- **Commit latency:** gray_code held stable → committed updates exactly 2+STABLE_CYCLES rising edges after the first edge that samples the new value. y and value_valid follow one edge later.
- **Glitches:** any input glitch shorter than STABLE_CYCLES cycles (post-sync) is discarded.
- **Frame:** 2·(SCAN_DIV+BLANK_CYCLES) cycles.
  - First U_ON begins BLANK_CYCLES edges after reset release.
  - Outputs change one edge after the state changes.
- **Segments vs enables:** an is never active in any cycle where display_code belongs to the other digit. Both change on the same edge, and a gap always separates the digits.
- **Reset mid-operation:** all registers return to reset values asynchronously. Output is blank immediately, with no partial-digit completion.

## Structure
- **Package display_pkg:**
  - scan_state_t enum {GAP_A, U_ON, GAP_B, T_ON}.
  - SEG_BLANK=7'h7F and AN_OFF=2'b11.
  - Function seg_of(logic [3:0]) returning the active-low segment map.
- **Sub-module gray_input_filter:** synchronizer plus stability counter. Outputs committed[3:0] and value_valid.
- **Conversion:** instantiate the existing gray_decoder for Gray→binary. Do not re-implement it.

## Test plan
All scenarios use SCAN_DIV=4, BLANK_CYCLES=1, STABLE_CYCLES=3.
1. Reset, gray_code=0000 → display_code=7'h7F and an=2'b11 during reset. After release: GAP_A for 1 cycle, then an=2'b10 with display_code=7'h40 for 4 cycles. T_ON shows blank, with an=2'b11.
2. gray_code 0000→1000 (binary 15) → value_valid pulses, then y=1. Next frame: units 7'h12 on an=2'b10, tens 7'h79 on an=2'b01.
3. gray_code=1111 (10) → units 7'h40, tens 7'h79, y=1. Then gray_code=0101 (6) → units 7'h02, tens blanked, y=0.
4. Pulse gray_code to 0001 for 2 cycles, then back → no value_valid, committed unchanged. Hold for ≥5 cycles → commit occurs exactly 5 edges after the first sample.
5. Commit arrives during U_ON → the current frame still shows the old digits; the next U_ON shows the new digits. Assert that an is never 2'b00 and that a gap cycle occurs between every digit change.
6. Assert rst_n mid-T_ON → outputs are blank in the same cycle, and the post-release sequence is identical to scenario 1.
